// File: rtl/floating_divider_seq.sv
// floating_divider_seq: sequential restoring FP divider, one quotient bit per clock, start/busy/done handshake
// Ports: clk, rst_n (async active-low), start, A/B operands in; busy, done pulse, result quotient out
module floating_divider_seq #(
    parameter int N    = 32,
    parameter int ES   = 8,
    parameter int SS   = N - ES - 1,
    parameter int BIAS = 2 ** (ES - 1) - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);
    localparam int CW = $clog2(SS + 2);
    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SS+1:0] r_q, r_d, q_q, q_d, diff, r_sel;
    logic [SS:0]   mb_q, mb_d;
    logic [ES+1:0] e_q, e_d, e_f;
    logic          sign_q, sign_d, done_q, done_d, ge;
    logic [N-1:0]  result_q, result_d;
    logic [SS-1:0] man;
    logic [ES-1:0] exp_f;
    always_comb begin
        ge    = r_q >= {1'b0, mb_q};
        diff  = r_q - {1'b0, mb_q};
        r_sel = ge ? diff : r_q;
        // integer bit clear means the quotient is in [0.5,1): take one more fraction bit
        e_f   = q_q[SS+1] ? e_q : e_q - 1'b1;
        man   = q_q[SS+1] ? q_q[SS:1] : q_q[SS-1:0];
        // MSB = negative (underflow); bit ES set while non-negative = above field range
        exp_f = e_f[ES+1] ? '0 : e_f[ES] ? '1 : e_f[ES-1:0];
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        mb_d     = mb_q;
        e_d      = e_q;
        sign_d   = sign_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = DIV;
                cnt_d   = '0;
                mb_d    = {1'b1, B[SS-1:0]};
                r_d     = {2'b01, A[SS-1:0]};
                q_d     = '0;
                sign_d  = A[N-1] ^ B[N-1];
                e_d     = (ES+2)'(A[N-2:SS]) - (ES+2)'(B[N-2:SS]) + (ES+2)'(BIAS);
            end
            DIV: begin
                q_d     = {q_q[SS:0], ge};
                r_d     = {r_sel[SS:0], 1'b0};
                cnt_d   = (cnt_q == CW'(SS + 1)) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q == CW'(SS + 1)) ? NORM : DIV;
            end
            NORM: begin
                result_d = {sign_q, exp_f, man};
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            mb_q     <= '0;
            e_q      <= '0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            mb_q     <= mb_d;
            e_q      <= e_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end
    assign busy   = state_q != IDLE;
    assign done   = done_q;
    assign result = result_q;
endmodule
